// File: rtl/tlut_pkg.sv
// Shared types and defaults for the temporal-LUT result drain.
package tlut_pkg;

  localparam int unsigned DefDimA     = 9;
  localparam int unsigned DefAccWidth = 13;
  localparam int unsigned DefWindow   = 16;
  localparam int unsigned DefCellLat  = 1;

  // $clog2 that never returns 0, so single-entry indices still get one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefLaneW = clog2_min1(DefDimA);

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StWait,
    StDrain
  } drain_state_t;

endpackage

// File: rtl/tlut_window_ctr.sv
// Loadable up-counter with terminal-count flag; times both the compute window
// and the cell-latency wait.
module tlut_window_ctr #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [Width-1:0] limit,
  output logic             tc
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/tlut_result_drain.sv
// Times one temporal-LUT compute window, captures the lane results and streams them
// out one lane per beat. Define TLUT_DRAIN_ZERO_SKIP_EN to skip zero-valued lanes.
module tlut_result_drain
  import tlut_pkg::*;
#(
  parameter int unsigned DIM_A     = DefDimA,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned WINDOW    = DefWindow,
  parameter int unsigned CELL_LAT  = DefCellLat,
  localparam int unsigned LaneW    = clog2_min1(DIM_A)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIM_A*ACC_WIDTH-1:0] product_acc,
  output logic                       cell_enable,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [LaneW-1:0]           out_lane,
  output logic                       out_last,
  output logic                       done
);

  localparam int unsigned CtrMax = (WINDOW > CELL_LAT) ? WINDOW : CELL_LAT;
  localparam int unsigned CtrW   = clog2_min1(CtrMax);

  drain_state_t state_q, state_d;

  logic [DIM_A-1:0][ACC_WIDTH-1:0] cap_lanes;
  logic [DIM_A-1:0][ACC_WIDTH-1:0] shadow_q;
  logic [LaneW-1:0]                lane_q;
  logic                            done_q;

  logic            ctr_load, ctr_inc, ctr_tc;
  logic [CtrW-1:0] ctr_limit;
  logic            xfer, capture;
  logic [LaneW-1:0] first_lane, next_lane;
  logic            is_last;

  assign cap_lanes = product_acc;

  tlut_window_ctr #(
    .Width (CtrW)
  ) u_window_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .limit (ctr_limit),
    .tc    (ctr_tc)
  );

  // Lane sequencing: first lane after capture, successor of lane_q, and last-beat flag.
`ifdef TLUT_DRAIN_ZERO_SKIP_EN
  logic [DIM_A-1:0] cap_nz, sh_nz;
  logic             has_next;

  always_comb begin
    cap_nz     = '0;
    sh_nz      = '0;
    first_lane = LaneW'(DIM_A - 1);
    next_lane  = lane_q;
    has_next   = 1'b0;
    for (int i = 0; i < DIM_A; i++) begin
      cap_nz[i] = |cap_lanes[i];
      sh_nz[i]  = |shadow_q[i];
    end
    // Descending scan leaves the lowest qualifying lane selected.
    for (int i = DIM_A - 1; i >= 0; i--) begin
      if (cap_nz[i]) begin
        first_lane = LaneW'(i);
      end
      if (sh_nz[i] && (i > int'(lane_q))) begin
        next_lane = LaneW'(i);
        has_next  = 1'b1;
      end
    end
    is_last = !has_next;
  end
`else
  always_comb begin
    first_lane = '0;
    next_lane  = lane_q + LaneW'(1);
    is_last    = (lane_q == LaneW'(DIM_A - 1));
  end
`endif

  assign xfer    = out_valid && out_ready;
  assign capture = (state_q == StWait) && ctr_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start)            state_d = StCompute;
      StCompute: if (ctr_tc)           state_d = StWait;
      StWait:    if (ctr_tc)           state_d = StDrain;
      StDrain:   if (xfer && is_last)  state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  always_comb begin
    cell_enable = (state_q == StCompute);
    busy        = (state_q != StIdle);
    out_valid   = (state_q == StDrain);
    out_last    = (state_q == StDrain) && is_last;
    out_data    = (state_q == StDrain) ? shadow_q[lane_q] : '0;
    out_lane    = (state_q == StDrain) ? lane_q : '0;
    done        = done_q;
    ctr_limit   = (state_q == StWait) ? CtrW'(CELL_LAT - 1) : CtrW'(WINDOW - 1);
    ctr_load    = ((state_q == StIdle) && start) ||
                  (((state_q == StCompute) || (state_q == StWait)) && ctr_tc);
    ctr_inc     = ((state_q == StCompute) || (state_q == StWait)) && !ctr_tc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      lane_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= xfer && is_last;
      if (capture) begin
        shadow_q <= cap_lanes;
        lane_q   <= first_lane;
      end else if (xfer) begin
        lane_q <= is_last ? '0 : next_lane;
      end
    end
  end

endmodule

// File: doc/tlut_result_drain.md
# tlut_result_drain

Result-side companion to `simd_cell`: owns the cell's `enable`, times one temporal-LUT compute window, captures the `DIM_A`-lane `product_acc` vector, and streams it out one lane per beat over a valid/ready interface. Sits between the SIMD cell array and the downstream accumulation/writeback path, replacing bench-style fixed-cycle waiting with a deterministic controller.

## Interface
- `DIM_A`, 9, number of product lanes
- `ACC_WIDTH`, 13, width of each lane result
- `WINDOW`, 16, compute-window length in cycles (2^INPUT_WIDTH for 4-bit temporal inputs)
- `CELL_LAT`, 1, cycles between `cell_enable` deassertion and `product_acc` being final (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  request one compute+drain job; sampled only in IDLE
- `product_acc`  in  DIM_A×ACC_WIDTH  packed lane results from `simd_cell`
- `cell_enable`  out  1  drives `simd_cell.enable`
- `busy`  out  1  high whenever state ≠ IDLE
- `out_valid`  out  1  beat available
- `out_ready`  in  1  downstream accepts beat
- `out_data`  out  ACC_WIDTH  lane value
- `out_lane`  out  $clog2(DIM_A)  lane index of current beat
- `out_last`  out  1  current beat is final of the job
- `done`  out  1  one-cycle pulse after final beat transfers

## Operation
- States: IDLE, COMPUTE, WAIT, DRAIN.
- IDLE: `start`=1 → COMPUTE, window counter loaded to 0.
- COMPUTE: `cell_enable`=1; counter increments; after exactly `WINDOW` cycles → WAIT.
- WAIT: `cell_enable`=0; `CELL_LAT` cycles; on the last WAIT cycle's closing edge `product_acc` is latched into a shadow register; → DRAIN, lane pointer = first lane to emit.
- DRAIN: `out_valid`=1, `out_data`=shadow[lane], `out_lane`=lane. Transfer = `out_valid && out_ready`. On transfer: advance to next emitted lane; if `out_last` → IDLE with `done` pulse the following cycle.
- `out_valid` never drops without a transfer; `out_data/out_lane/out_last` stable while `out_valid && !out_ready`.
- `start` outside IDLE ignored (no queuing). `start` in the `done` cycle is accepted (state is IDLE).
- `product_acc` changes after capture do not affect the drained values.
- Reset (any state, incl. mid-drain): state IDLE, counters 0, shadow cleared to 0; next job restarts at lane 0.

## Timing
- Reset values: `cell_enable`, `busy`, `out_valid`, `out_last`, `done` = 0; `out_data`, `out_lane` = 0.
- `start` sampled at edge of cycle k → `cell_enable`=1 for cycles k+1…k+WINDOW; WAIT cycles k+WINDOW+1…k+WINDOW+CELL_LAT; `out_valid` first high at cycle k+WINDOW+CELL_LAT+1.
- With `out_ready` tied high: one beat per cycle, DIM_A beats back-to-back; `done` the cycle after the last beat; job length WINDOW+CELL_LAT+DIM_A+1 cycles from `start` to `done`.
- `busy` high from k+1 through the last-beat cycle.
- All outputs registered; no combinational path `out_ready` → `out_valid`.

## Configuration
- `TLUT_DRAIN_ZERO_SKIP_EN` defined: lanes whose captured value is 0 are skipped; `out_last` marks the highest non-zero lane; if all lanes are zero, exactly one beat (lane DIM_A-1, data 0, `out_last`=1) is emitted.
- Not defined: all DIM_A lanes always emitted in order 0…DIM_A-1; `out_last` on lane DIM_A-1.

## Structure
- `tlut_pkg`: state enum (`drain_state_t`), default `DIM_A`/`ACC_WIDTH`/`WINDOW`/`CELL_LAT`, lane-index width constant.
- Sub-module `tlut_window_ctr`: loadable up-counter with terminal-count flag, reused for COMPUTE and WAIT timing.

## Test plan
- Reset: `rst`=1 for 3 cycles mid-COMPUTE → all outputs 0 next cycle, `busy`=0.
- Basic job: lane i = 10·i+1, `out_ready`=1, `start` at cycle k → `cell_enable` high k+1…k+16, beats lanes 0…8 = 1,11,…,81 at k+18…k+26, `out_last` on lane 8, `done` at k+27.
- Backpressure: `out_ready` alternating 0/1 → 9 transfers over 18 cycles, data held stable while stalled, no beat lost or duplicated.
- Ignored start / capture isolation: `start` pulsed during COMPUTE and DRAIN, `product_acc` changed during DRAIN → single job, drained values equal captured values.
- Mid-drain reset after lane 3 transfers → outputs 0; new `start` drains lanes 0…8 fresh.
- `TLUT_DRAIN_ZERO_SKIP_EN`: lanes 1,4 = 0 → 7 beats, `out_last` on lane 8; all lanes 0 → one beat, lane 8, data 0, `out_last`=1.
